// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus initiator: frame opcodes,
// response bytes and the frame-handling state encoding.
package reg_bus_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_WRITE,
    ST_RD_WAIT,
    ST_SEND
  } state_t;

  // States in which an incoming command byte may be consumed.
  function automatic logic takes_rx(input state_t s);
    return (s == ST_IDLE) || (s == ST_GET_ADDR) || (s == ST_GET_DATA);
  endfunction

  // States in which the inter-byte timeout is armed.
  function automatic logic mid_frame(input state_t s);
    return (s == ST_GET_ADDR) || (s == ST_GET_DATA);
  endfunction

endpackage

// File: rtl/reg_bus_master_frame_timer.sv
// Inter-byte idle timer. Counts cycles while run is high and no clear
// occurs; expired stays high once TIMEOUT idle cycles have elapsed.
// TIMEOUT=0 disables the timer entirely (expired tied low).
module frame_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic res_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] count;

      assign expired = (count == CW'(TIMEOUT));

      // Idle-cycle counter, saturating at TIMEOUT.
      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (run && !expired) begin
          count <= count + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/reg_bus_master.sv
// Byte-stream to register-bus initiator. Parses write (57 addr data) and
// read (52 addr) frames, drives the shared register bus and returns read
// data / NAK bytes on the tx stream.
// Build option: define REG_BUS_MASTER_WR_ACK_EN to return an ACK byte
// after every write; otherwise writes are silent.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int READ_WAIT  = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_we,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy
);

  localparam logic [DATA_WIDTH-1:0] OP_WR_B   = DATA_WIDTH'(OP_WR);
  localparam logic [DATA_WIDTH-1:0] OP_RD_B   = DATA_WIDTH'(OP_RD);
  localparam logic [DATA_WIDTH-1:0] RSP_NAK_B = DATA_WIDTH'(RSP_NAK);
`ifdef REG_BUS_MASTER_WR_ACK_EN
  localparam logic [DATA_WIDTH-1:0] RSP_ACK_B = DATA_WIDTH'(RSP_ACK);
`endif
  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

  state_t                  state;
  state_t                  state_next;
  logic                    is_read;
  logic [3:0]              wait_cnt;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   tx_q;

  logic                    rx_accept;
  logic                    ld_op;
  logic                    ld_addr;
  logic                    ld_wdata;
  logic                    ld_tx;
  logic [DATA_WIDTH-1:0]   tx_next;
  logic                    clr_wait;
  logic                    timer_run;
  logic                    timer_clear;
  logic                    timed_out;

  // rx_ready is forced low during reset, not just after the state resets.
  assign rx_ready  = res_n && takes_rx(state);
  assign rx_accept = rx_valid && rx_ready;
  assign tx_valid  = (state == ST_SEND);
  assign bus_we    = (state == ST_WRITE);
  assign busy      = (state != ST_IDLE);
  assign tx_data   = tx_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  assign timer_run   = mid_frame(state);
  assign timer_clear = rx_accept || !timer_run;

  frame_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_frame_timer (
    .clk    (clk),
    .res_n  (res_n),
    .clear  (timer_clear),
    .run    (timer_run),
    .expired(timed_out)
  );

  // State register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath load strobes.
  always_comb begin
    state_next = state;
    ld_op      = 1'b0;
    ld_addr    = 1'b0;
    ld_wdata   = 1'b0;
    ld_tx      = 1'b0;
    tx_next    = '0;
    clr_wait   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_accept) begin
          if (rx_data == OP_WR_B || rx_data == OP_RD_B) begin
            ld_op      = 1'b1;
            state_next = ST_GET_ADDR;
          end else begin
            ld_tx      = 1'b1;
            tx_next    = RSP_NAK_B;
            state_next = ST_SEND;
          end
        end
      end
      ST_GET_ADDR: begin
        // An arriving byte wins over a simultaneous timeout.
        if (rx_accept) begin
          ld_addr = 1'b1;
          if (is_read) begin
            clr_wait   = 1'b1;
            state_next = ST_RD_WAIT;
          end else begin
            state_next = ST_GET_DATA;
          end
        end else if (timed_out) begin
          state_next = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (rx_accept) begin
          ld_wdata   = 1'b1;
          state_next = ST_WRITE;
        end else if (timed_out) begin
          state_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
`ifdef REG_BUS_MASTER_WR_ACK_EN
        ld_tx      = 1'b1;
        tx_next    = RSP_ACK_B;
        state_next = ST_SEND;
`else
        state_next = ST_IDLE;
`endif
      end
      ST_RD_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          ld_tx      = 1'b1;
          tx_next    = bus_rdata;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Frame datapath: opcode, bus address/data, response byte, read wait.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      is_read  <= 1'b0;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tx_q     <= '0;
    end else begin
      if (ld_op) begin
        is_read <= (rx_data == OP_RD_B);
      end
      if (ld_addr) begin
        addr_q <= rx_data;
      end
      if (ld_wdata) begin
        wdata_q <= rx_data;
      end
      if (ld_tx) begin
        tx_q <= tx_next;
      end
      if (clr_wait) begin
        wait_cnt <= '0;
      end else if (state == ST_RD_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: frame-level reference model plus directed
// frames with hand-computed expectations. Honours REG_BUS_MASTER_WR_ACK_EN.
module tb_reg_bus_master;

  localparam int RW = 2;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       res_n = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic [7:0] bus_rdata = 8'h00;
  logic       busy;

  always #5 clk = ~clk;

  reg_bus_master #(
    .DATA_WIDTH(8),
    .READ_WAIT (RW),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .res_n    (res_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_rdata(bus_rdata),
    .busy     (busy)
  );

  // Peripheral: registered read, write on strobe.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus_we) mem[bus_addr] <= bus_wdata;
    bus_rdata <= mem[bus_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model state: bytes of the frame in progress, pending response.
  logic [7:0] mmem [256];
  logic [7:0] m_fb [$];
  int         m_last = 0;
  bit         m_pend = 0;
  int         m_resp_cyc = 0;
  logic [7:0] m_resp = 8'h00;
  int         m_we_cyc = -1;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;

  // Observations gathered for the directed checks.
  int         we_cnt = 0;
  logic [7:0] we_addr = 8'h00;
  logic [7:0] we_data = 8'h00;
  int         rise_cyc = -1;
  bit         prev_txv = 0;
  logic [7:0] txq [$];
  int         acc_cyc = 0;

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk) begin
    bit e_we, e_txv, e_rxr, e_busy;
    if (!res_n) begin
      check("rst_rx_ready", rx_ready, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      check("rst_bus_we", bus_we, 0);
      check("rst_busy", busy, 0);
      m_fb.delete();
      m_pend = 0;
      m_we_cyc = -1;
      m_addr = 8'h00;
      m_wdata = 8'h00;
      prev_txv = 0;
    end else begin
      e_we   = (cyc == m_we_cyc);
      e_txv  = m_pend && (cyc >= m_resp_cyc);
      e_rxr  = !e_we && !m_pend;
      e_busy = !(e_rxr && m_fb.size() == 0);
      check("rx_ready", rx_ready, e_rxr);
      check("tx_valid", tx_valid, e_txv);
      check("bus_we", bus_we, e_we);
      check("busy", busy, e_busy);
      check("bus_addr", bus_addr, m_addr);
      check("bus_wdata", bus_wdata, m_wdata);
      if (e_txv) check("tx_data", tx_data, m_resp);

      if (bus_we) begin
        we_cnt++;
        we_addr = bus_addr;
        we_data = bus_wdata;
      end
      if (tx_valid && !prev_txv) rise_cyc = cyc;
      prev_txv = tx_valid;
      if (tx_valid && tx_ready) txq.push_back(tx_data);

      if (e_txv && tx_ready) m_pend = 0;
      if (e_rxr && rx_valid) begin
        m_last = cyc;
        m_fb.push_back(rx_data);
        if (m_fb[0] != 8'h57 && m_fb[0] != 8'h52) begin
          m_pend = 1; m_resp_cyc = cyc + 1; m_resp = 8'h15;
          m_fb.delete();
        end else if (m_fb.size() == 2) begin
          m_addr = rx_data;
          if (m_fb[0] == 8'h52) begin
            m_pend = 1; m_resp_cyc = cyc + RW + 1; m_resp = mmem[rx_data];
            m_fb.delete();
          end
        end else if (m_fb.size() == 3) begin
          m_wdata = rx_data;
          m_we_cyc = cyc + 1;
          mmem[m_addr] = rx_data;
`ifdef REG_BUS_MASTER_WR_ACK_EN
          m_pend = 1; m_resp_cyc = cyc + 2; m_resp = 8'h06;
`endif
          m_fb.delete();
        end
      end else if (m_fb.size() != 0 && (cyc - m_last) >= TO + 1) begin
        m_fb.delete();
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bit acc = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = rx_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (!acc) check("send_accept", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] txq_first();
    return (txq.size() > 0) ? {24'h0, txq[0]} : 32'hDEAD;
  endfunction

  int base;
  int t;

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i) ^ 8'h5A;
      mmem[i] = 8'(i) ^ 8'h5A;
    end
    mem[8'h21]  = 8'h01;
    mmem[8'h21] = 8'h01;

    #1 res_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 res_n = 1'b1;
    idle(2);

    // Write 57 22 05
    base = we_cnt; txq.delete();
    send(8'h57); send(8'h22); send(8'h05);
    idle(5);
    check("wr_we_count", we_cnt - base, 1);
    check("wr_addr", we_addr, 8'h22);
    check("wr_data", we_data, 8'h05);
    check("wr_mem", mem[8'h22], 8'h05);
`ifdef REG_BUS_MASTER_WR_ACK_EN
    check("wr_ack_count", txq.size(), 1);
    check("wr_ack_byte", txq_first(), 8'h06);
`else
    check("wr_no_rsp", txq.size(), 0);
`endif

    // Read 52 21
    base = we_cnt; txq.delete();
    send(8'h52); send(8'h21);
    t = acc_cyc;
    idle(8);
    check("rd_count", txq.size(), 1);
    check("rd_byte", txq_first(), 8'h01);
    check("rd_latency", rise_cyc - t, 3);
    check("rd_no_we", we_cnt - base, 0);

    // Bad opcode, then a normal read
    base = we_cnt; txq.delete();
    send(8'h41);
    t = acc_cyc;
    idle(4);
    check("nak_count", txq.size(), 1);
    check("nak_byte", txq_first(), 8'h15);
    check("nak_latency", rise_cyc - t, 1);
    check("nak_no_we", we_cnt - base, 0);
    check("nak_idle", busy, 0);
    txq.delete();
    send(8'h52); send(8'h22);
    idle(8);
    check("rd2_byte", txq_first(), 8'h05);

    // Timeout mid-frame, then a fresh write
    base = we_cnt; txq.delete();
    send(8'h57); send(8'h22);
    idle(25);
    check("to_no_we", we_cnt - base, 0);
    check("to_no_tx", txq.size(), 0);
    check("to_idle", busy, 0);
    send(8'h57); send(8'h22); send(8'h03);
    idle(5);
    check("to_wr_count", we_cnt - base, 1);
    check("to_wr_data", we_data, 8'h03);
    check("to_wr_mem", mem[8'h22], 8'h03);

    // Slow frame with gaps below the timeout
    base = we_cnt;
    send(8'h57); idle(15); send(8'h30); idle(15); send(8'h07);
    idle(5);
    check("slow_we_count", we_cnt - base, 1);
    check("slow_addr", we_addr, 8'h30);
    check("slow_data", we_data, 8'h07);

    // Read with tx back-pressure
    txq.delete(); tx_ready = 1'b0;
    send(8'h52); send(8'h21);
    for (int i = 0; i < 30 && !tx_valid; i++) @(negedge clk);
    check("bp_tx_valid", tx_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_hold_valid", tx_valid, 1);
      check("bp_hold_data", tx_data, 8'h01);
      check("bp_hold_rx_ready", rx_ready, 0);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_done", tx_valid, 0);
    idle(2);
    check("bp_count", txq.size(), 1);
    check("bp_byte", txq_first(), 8'h01);

    // Reset in the middle of a write frame
    base = we_cnt; txq.delete();
    send(8'h57); send(8'h22);
    #1 res_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rx_ready", rx_ready, 0);
    check("arst_bus_addr", bus_addr, 0);
    check("arst_bus_wdata", bus_wdata, 0);
    check("arst_tx_data", tx_data, 0);
    repeat (2) @(posedge clk);
    #1 res_n = 1'b1;
    idle(3);
    check("arst_no_we", we_cnt - base, 0);
    check("arst_no_tx", txq.size(), 0);
    send(8'h57); send(8'h40); send(8'h09);
    idle(5);
    check("post_rst_we", we_cnt - base, 1);
    check("post_rst_addr", we_addr, 8'h40);
    check("post_rst_data", we_data, 8'h09);
    txq.delete();
    send(8'h52); send(8'h40);
    idle(8);
    check("post_rst_rd", txq_first(), 8'h09);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Byte-stream-to-register-bus initiator: accepts command frames from a serial receiver (valid/ready byte stream), issues single write or read transactions on the shared `addr`/`data_in`/`data_out`/`we` register bus that the peripheral blocks (gate selector, PWM channels) respond to, and returns read data or status bytes on a transmit byte stream. It sits between the host link and every register-mapped peripheral, acting as the bus owner.

## Interface
- `DATA_WIDTH`, 8: bus address and data width; also the byte width of both streams.
- `READ_WAIT`, 2: cycles from `bus_addr` valid to sampling `bus_rdata`; legal 1..15.
- `TIMEOUT`, 1000: idle cycles allowed between bytes of one frame; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on the rising edge.
- `res_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  DATA_WIDTH  incoming command byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  block accepts a byte; transfer occurs when `rx_valid && rx_ready`.
- `tx_data`  out  DATA_WIDTH  response byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts; transfer occurs when `tx_valid && tx_ready`.
- `bus_addr`  out  DATA_WIDTH  register address to peripherals.
- `bus_wdata`  out  DATA_WIDTH  write data to peripherals.
- `bus_we`  out  1  write strobe, one cycle per write.
- `bus_rdata`  in  DATA_WIDTH  registered read data from the addressed peripheral.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Frames: write = `0x57`, addr, data. Read = `0x52`, addr. Any other first byte produces a NAK (`0x15`).
- States: IDLE, GET_ADDR, GET_DATA, WRITE, RD_WAIT, SEND.
- IDLE: `rx_ready`=1. On a `0x57` or `0x52` byte go to GET_ADDR and latch the opcode. On any other byte load NAK into `tx_data` and go to SEND.
- GET_ADDR: `rx_ready`=1. On a byte, latch it into `bus_addr`. Write goes to GET_DATA. Read clears the wait counter and goes to RD_WAIT.
- GET_DATA: `rx_ready`=1. On a byte, latch it into `bus_wdata` and go to WRITE.
- WRITE: `bus_we`=1 for exactly this one cycle. Next state is SEND with ACK `0x06`, or IDLE (see Configuration).
- RD_WAIT: count READ_WAIT cycles. In the last cycle, capture `bus_rdata` into `tx_data` and go to SEND.
- SEND: `tx_valid`=1, `tx_data` stable until the handshake, then go to IDLE. `rx_ready`=0 in WRITE, RD_WAIT and SEND; bytes offered in those states are not consumed.
- Timeout: in GET_ADDR or GET_DATA, a counter increments each cycle with no accepted byte and clears on every accepted byte. When it reaches TIMEOUT, return to IDLE silently: no bus cycle and no response byte.
- `bus_addr` and `bus_wdata` hold their last values between frames.

## Timing
- Reset values: `rx_ready`=0 while `res_n` is low and 1 in IDLE afterwards. `tx_valid`=0, `tx_data`=0, `bus_addr`=0, `bus_wdata`=0, `bus_we`=0, `busy`=0, state IDLE.
- Write: `bus_we` is high in cycle N+1, where cycle N is the handshake of the data byte. `bus_addr` and `bus_wdata` are valid in cycle N+1.
- Read: `bus_addr` is valid from cycle N+1, where cycle N is the handshake of the addr byte. `bus_rdata` is sampled at the end of cycle N+READ_WAIT. `tx_valid` rises in cycle N+READ_WAIT+1.
- NAK: `tx_valid` rises in the cycle after the bad opcode byte is accepted.
- Reset mid-frame: abort immediately to the reset values. A `bus_we` pulse in progress is cut.

## Configuration
- `REG_BUS_MASTER_WR_ACK_EN` defined: WRITE goes to SEND with `tx_data`=`0x06`, so every write returns one ACK byte.
- Undefined: WRITE goes directly to IDLE and writes produce no response. Reads and NAKs behave identically in both builds.

## Structure
- Shared package `reg_bus_pkg`:
  - opcode constants `OP_WR`=`0x57`, `OP_RD`=`0x52`;
  - response constants `RSP_ACK`=`0x06`, `RSP_NAK`=`0x15`;
  - the state enum typedef.
- One sub-module `frame_timer`: parameterized by TIMEOUT, with inputs `clear` and `run` and output `expired`; counter width is `$clog2(TIMEOUT+1)`, and `expired` is tied to 0 when TIMEOUT=0.

## Test plan
- Stream `57 22 05` -> `bus_we` high for exactly one cycle with `bus_addr`=`0x22` and `bus_wdata`=`0x05`. With the ACK macro, `tx_data`=`0x06`; without it, no tx byte.
- Slave model returns `0x01` at address `0x21`; stream `52 21` -> `tx_data`=`0x01`, `tx_valid` rising READ_WAIT+1 cycles after the addr byte, and `bus_we` never high.
- Stream `41` -> `tx_data`=`0x15`, no bus cycle, state back to IDLE. A following `52 22` is serviced normally.
- TIMEOUT=20, stream `57 22` then 20 idle cycles -> IDLE, no `bus_we`, no tx byte. A following `57 22 03` writes `0x03`.
- Read with `tx_ready` held low for 10 cycles -> `tx_data` stable, `tx_valid` high, `rx_ready` low throughout. Completes on the first `tx_ready` cycle.
- Assert `res_n` low after `57 22` -> all outputs at reset values asynchronously, no `bus_we`. A fresh frame after release works.
